// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative restoring divider for the EX stage, {remainder, quotient} result.
// Signed DIV support is built only when DIV_SIGNED_EN is defined; otherwise every divide is unsigned.
module ex_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_start_i,
  input  logic                  div_annul_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_e;
  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*DATA_W:0]     dividend_q, dividend_d, shifted, step;
  logic [DATA_W-1:0]     divisor_q, divisor_d, op1_abs, op2_abs, quo, rem;
  logic [DATA_W:0]       diff;
  logic                  ge, neg1, neg2, negq_q, negq_d, negr_q, negr_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;
  logic                  unused_top;
`ifdef DIV_SIGNED_EN
  assign neg1    = signed_i & opdata1_i[DATA_W-1];
  assign neg2    = signed_i & opdata2_i[DATA_W-1];
  assign op1_abs = neg1 ? -opdata1_i : opdata1_i;
  assign op2_abs = neg2 ? -opdata2_i : opdata2_i;
  assign quo     = negq_q ? -step[DATA_W-1:0] : step[DATA_W-1:0];
  assign rem     = negr_q ? -step[2*DATA_W-1:DATA_W] : step[2*DATA_W-1:DATA_W];
`else
  logic unused_sign;
  assign neg1        = 1'b0;
  assign neg2        = 1'b0;
  assign op1_abs     = opdata1_i;
  assign op2_abs     = opdata2_i;
  assign quo         = step[DATA_W-1:0];
  assign rem         = step[2*DATA_W-1:DATA_W];
  assign unused_sign = ^{signed_i, negq_q, negr_q};
`endif
  // Partial remainder stays below the divisor, so the top bit never survives a shift.
  assign unused_top = dividend_q[2*DATA_W];
  assign shifted    = {dividend_q[2*DATA_W-1:0], 1'b0};
  assign diff       = shifted[2*DATA_W:DATA_W] - {1'b0, divisor_q};
  assign ge         = shifted[2*DATA_W:DATA_W] >= {1'b0, divisor_q};
  assign step       = ge ? {diff, shifted[DATA_W-1:1], 1'b1} : shifted;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    result_d   = result_q;
    ready_d    = ready_q;
    case (state_q)
      S_IDLE: if (div_start_i && !div_annul_i) begin
        state_d    = (opdata2_i == '0) ? S_DIVZERO : S_ON;
        cnt_d      = '0;
        dividend_d = {{(DATA_W+1){1'b0}}, op1_abs};
        divisor_d  = op2_abs;
        negq_d     = neg1 ^ neg2;
        negr_d     = neg1;
      end
      S_DIVZERO: begin
        state_d  = div_annul_i ? S_IDLE : S_END;
        ready_d  = !div_annul_i;
        result_d = '0;
      end
      S_ON: if (div_annul_i) begin
        state_d  = S_IDLE;
        ready_d  = 1'b0;
        result_d = '0;
      end else begin
        dividend_d = step;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W - 1)) begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = {rem, quo};
        end
      end
      default: if (div_annul_i || !div_start_i) begin
        state_d  = S_IDLE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      negq_q     <= negq_d;
      negr_q     <= negr_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end
  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = div_start_i & ~ready_q & ~div_annul_i & ~rst;
endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: directed divides checked against an arithmetic model every cycle plus literal results.
module tb_ex_div_unit;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, annul = 1'b0, sgn = 1'b0;
  logic [31:0] op1 = '0, op2 = '0;
  logic [63:0] result;
  logic        ready, stall;
  int          total = 0, bad = 0;
  logic        armed = 1'b0;
  logic        m_act = 1'b0, m_rdy = 1'b0;
  logic [63:0] m_res = '0, m_val = '0;
  int          m_left = 0;

  ex_div_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .div_start_i(start), .div_annul_i(annul), .signed_i(sgn),
    .opdata1_i(op1), .opdata2_i(op2), .result_o(result), .ready_o(ready), .stallreq_o(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 0) return 64'd0;
`ifdef DIV_SIGNED_EN
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
`endif
    sa = longint'(a);
    sb = longint'(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction-level model: countdown of edges until the result appears.
  always @(posedge clk) begin
    if (rst) begin
      m_act <= 1'b0;
      m_rdy <= 1'b0;
      m_res <= '0;
    end else if (m_act) begin
      if (annul) m_act <= 1'b0;
      else if (m_left == 1) begin
        m_act <= 1'b0;
        m_rdy <= 1'b1;
        m_res <= m_val;
      end else m_left <= m_left - 1;
    end else if (m_rdy) begin
      if (annul || !start) begin
        m_rdy <= 1'b0;
        m_res <= '0;
      end
    end else if (start && !annul) begin
      m_act  <= 1'b1;
      m_left <= (op2 == 0) ? 1 : 32;
      m_val  <= model(op1, op2, sgn);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (armed) begin
    chk("model_ready", 64'(ready), 64'(m_rdy));
    chk("model_result", result, m_res);
    chk("model_stall", 64'(stall), 64'(start && !m_rdy && !annul && !rst));
  end

  task automatic run(input string nm, input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [63:0] lit, input int lat, input int hold);
    int n;
    logic got;
    @(posedge clk);
    #2;
    op1 = a; op2 = b; sgn = s; start = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(posedge clk);
      n++;
      #2;
      if (n == 1) begin
        op1 = ~a;
        op2 = a ^ 32'h5;
      end
      @(negedge clk);
      got = ready;
    end
    chk({nm, "_latency"}, 64'(n), 64'(lat));
    chk({nm, "_result"}, result, lit);
    repeat (hold) begin
      @(negedge clk);
      chk({nm, "_hold"}, result, lit);
    end
    @(posedge clk);
    #2 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_drop_ready"}, 64'(ready), 64'd0);
    chk({nm, "_drop_result"}, result, 64'd0);
  endtask

  initial begin
    logic [63:0] lit3, lit5;
`ifdef DIV_SIGNED_EN
    lit3 = 64'hFFFFFFFF_FFFFFFFD;
    lit5 = 64'h00000000_80000000;
`else
    lit3 = 64'h00000001_7FFFFFFC;
    lit5 = 64'h80000000_00000000;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    armed = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    run("udiv_100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 0);
    run("divzero", 32'h1234, 32'd0, 1'b0, 64'd0, 2, 0);
    run("neg7_div_2", 32'hFFFFFFF9, 32'd2, 1'b1, lit3, 33, 0);
    // Annul after ten ON cycles.
    @(posedge clk);
    #2 op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (11) @(posedge clk);
    #2 annul = 1'b1;
    @(negedge clk);
    chk("annul_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #2 annul = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("annul_ready", 64'(ready), 64'd0);
    chk("annul_result", result, 64'd0);
    chk("annul_stall_after", 64'(stall), 64'd0);
    run("after_annul_9_3", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33, 0);
    run("hold5", 32'hDEADBEEF, 32'h00001234, 1'b0,
        {32'(32'hDEADBEEF % 32'h1234), 32'(32'hDEADBEEF / 32'h1234)}, 33, 5);
    run("ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, lit5, 33, 1);
    // Reset in the middle of a divide.
    @(posedge clk);
    #2 op1 = 32'd100; op2 = 32'd7; sgn = 1'b0; start = 1'b1;
    repeat (21) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_result", result, 64'd0);
    @(posedge clk);
    #2 rst = 1'b0; start = 1'b0;
    run("after_rst_100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 0);
    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
